// File: rtl/md_pkg.sv
// md_pkg
// Shared definitions for the multiply/divide unit: operation codes carried
// on md_op, default busy latencies, and small classification helpers used
// by both the control logic (md_unit) and the datapath (md_calc).
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Plain 64-bit products written straight into HI/LO.
  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Multiply-accumulate family (only honoured when MDU_MADD_EN is defined).
  function automatic logic is_madd(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mt(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Ops whose multiply product is signed.
  function automatic logic is_signed_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/md_if.sv
// md_if
// Connection between the E stage and the multiply/divide unit.
//   start  : launch the op in md_op this cycle
//   md_op  : operation code (md_pkg::md_op_e values)
//   rs_val : operand A (forwarded rs)
//   rt_val : operand B (forwarded rt)
//   req    : exception/interrupt taken this cycle, blocks any launch/MT write
//   busy   : operation in flight
//   hi, lo : architectural HI/LO registers
// master = E-stage side (drives the request), slave = md_unit.
interface md_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, req,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, req,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_calc.sv
// md_calc
// Purely combinational result generator working on the operands captured
// at launch.
//   op       in  4   captured operation code
//   a, b     in  32  captured rs / rt operands
//   res_hi   out 32  product[63:32] or remainder
//   res_lo   out 32  product[31:0]  or quotient
//   div_zero out 1   divisor is zero
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    // Low 64 bits of a 64x64 product of sign-extended operands equal the
    // signed 32x32 product, so one unsigned multiplier serves both cases.
    if (is_signed_mul(op)) begin
      prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    end else begin
      prod = {32'd0, a} * {32'd0, b};
    end

    // Signed divide runs on magnitudes, then fixes signs: quotient
    // truncates toward zero, remainder follows the dividend. The
    // 0x80000000 / -1 case falls out naturally (magnitude 0x80000000
    // negated wraps back to 0x80000000, remainder 0).
    signed_div = (op == OP_DIV);
    a_neg      = signed_div & a[31];
    b_neg      = signed_div & b[31];
    abs_a      = a_neg ? (~a + 32'd1) : a;
    abs_b      = b_neg ? (~b + 32'd1) : b;
    div_zero   = (b == 32'd0);
    q_u        = div_zero ? 32'd0 : (abs_a / abs_b);
    r_u        = div_zero ? 32'd0 : (abs_a % abs_b);
    quot       = (a_neg ^ b_neg) ? (~q_u + 32'd1) : q_u;
    rem        = a_neg ? (~r_u + 32'd1) : r_u;

    if (is_div(op)) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit
// E-stage multiply/divide unit owning HI/LO. One op launches per start
// pulse when not busy and no exception is being taken; the result is
// committed to HI/LO after a fixed latency on the same edge busy falls,
// so a reader never sees new HI/LO while busy is high.
//   clk    in  1  clock
//   reset  in  1  synchronous active-high reset
//   bus    md_if.slave (start, md_op, rs_val, rt_val, req -> busy, hi, lo)
// Parameters: MULT_LAT / DIV_LAT = busy cycles for multiply / divide ops.
// Build option: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU;
// otherwise those codes are ignored like any undefined op.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
)
(
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] count_reg;
  logic             first_reg;
  logic [3:0]       op_reg;
  logic [31:0]      a_reg;
  logic [31:0]      b_reg;
  logic [31:0]      shadow_hi_reg;
  logic [31:0]      shadow_lo_reg;
  logic             shadow_dz_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;

  logic             busy;
  logic             launch;
  logic             is_long;
  logic [CNT_W-1:0] lat_sel;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_dz;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_dz;
  logic [63:0]      acc_next;

  md_calc u_calc (
    .op       (op_reg),
    .a        (a_reg),
    .b        (b_reg),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .div_zero (calc_dz)
  );

  assign busy     = (count_reg != '0);
  assign bus.busy = busy;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  always_comb begin
    launch = bus.start & ~bus.req & ~busy;
`ifdef MDU_MADD_EN
    is_long = is_mul(bus.md_op) | is_div(bus.md_op) | is_madd(bus.md_op);
`else
    is_long = is_mul(bus.md_op) | is_div(bus.md_op);
`endif
    lat_sel = is_div(bus.md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  end

  // Value {HI,LO} takes at commit. The shadow is only loaded on the first
  // busy edge, so the calc output is used directly if commit happens then
  // (latency of one).
  always_comb begin
    res_hi   = first_reg ? calc_hi : shadow_hi_reg;
    res_lo   = first_reg ? calc_lo : shadow_lo_reg;
    res_dz   = first_reg ? calc_dz : shadow_dz_reg;
    acc_next = {hi_reg, lo_reg};
    if (is_div(op_reg)) begin
      if (!res_dz) begin
        acc_next = {res_hi, res_lo};
      end
    end
`ifdef MDU_MADD_EN
    else if ((op_reg == OP_MADD) || (op_reg == OP_MADDU)) begin
      acc_next = {hi_reg, lo_reg} + {res_hi, res_lo};
    end else if ((op_reg == OP_MSUB) || (op_reg == OP_MSUBU)) begin
      acc_next = {hi_reg, lo_reg} - {res_hi, res_lo};
    end
`endif
    else begin
      acc_next = {res_hi, res_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      first_reg     <= 1'b0;
      op_reg        <= 4'd0;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      shadow_hi_reg <= 32'd0;
      shadow_lo_reg <= 32'd0;
      shadow_dz_reg <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
    end else begin
      // launch implies ~busy, so launch and the busy branch never collide.
      if (launch && is_long) begin
        op_reg    <= bus.md_op;
        a_reg     <= bus.rs_val;
        b_reg     <= bus.rt_val;
        count_reg <= lat_sel;
        first_reg <= 1'b1;
      end else if (launch && (bus.md_op == OP_MTHI)) begin
        hi_reg <= bus.rs_val;
      end else if (launch && (bus.md_op == OP_MTLO)) begin
        lo_reg <= bus.rs_val;
      end

      if (busy) begin
        first_reg <= 1'b0;
        count_reg <= count_reg - CNT_W'(1);
        if (first_reg) begin
          shadow_hi_reg <= calc_hi;
          shadow_lo_reg <= calc_lo;
          shadow_dz_reg <= calc_dz;
        end
        if (count_reg == CNT_W'(1)) begin
          {hi_reg, lo_reg} <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
// Scoreboard bench for md_unit: stimulus pushes the expected HI/LO (and
// busy length) for each transaction; a negedge monitor pops and compares
// when busy falls, or when the stimulus raises a probe strobe for
// transactions that never raise busy.
module tb_md_unit;
  import md_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;   // 0: probe entry, expect busy low
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic strobe;

  md_if bus();

  md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   fails    = 0;
  logic prev_busy = 1'b0;
  int   busy_cnt = 0;

  task automatic check32(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic pop_check(bit on_fall);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_event: got a %s with empty scoreboard, expected none",
               on_fall ? "busy fall" : "probe");
    end else begin
      e = exp_q.pop_front();
      check32({e.name, ".hi"}, bus.hi, e.hi);
      check32({e.name, ".lo"}, bus.lo, e.lo);
      if (on_fall) begin
        check32({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
      end else begin
        check32({e.name, ".busy"}, {31'd0, bus.busy}, 32'd0);
      end
      $display("txn %-18s hi=0x%08h lo=0x%08h busy_cycles=%0d", e.name, bus.hi, bus.lo,
               on_fall ? busy_cnt : 0);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (prev_busy && (bus.busy === 1'b0)) begin
      pop_check(1'b1);
      busy_cnt = 0;
    end
    if (strobe === 1'b1) begin
      pop_check(1'b0);
    end
    if (bus.busy === 1'b1) begin
      busy_cnt++;
    end
    prev_busy = (bus.busy === 1'b1);
  end

  task automatic push_exp(logic [31:0] hi, logic [31:0] lo, int lat, string name);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.lat = lat;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic rq);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.req    = rq;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
    bus.req   = 1'b0;
  endtask

  task automatic probe(logic [31:0] hi, logic [31:0] lo, string name);
    @(posedge clk);
    #1;
    push_exp(hi, lo, 0, name);
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy !== 1'b0) && (n < 40));
    if (bus.busy !== 1'b0) begin
      checks++;
      fails++;
      $display("FAIL %s.timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, n);
    end
  endtask

  initial begin
    reset      = 1'b1;
    strobe     = 1'b0;
    bus.start  = 1'b0;
    bus.md_op  = OP_NONE;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    bus.req    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    probe(32'h0, 32'h0, "reset");

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFA, 5, "mult");
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle("mult");

    push_exp(32'h00000002, 32'hFFFFFFFA, 5, "multu");
    issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle("multu");

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div");
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle("div");

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 10, "divu_by_zero");
    issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
    wait_idle("divu_by_zero");

    push_exp(32'h00000000, 32'h80000000, 10, "div_overflow");
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle("div_overflow");

    // MTHI then MTLO on consecutive cycles, checked one cycle after each.
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.md_op  = OP_MTHI;
    bus.rs_val = 32'h12345678;
    @(posedge clk);
    #1;
    bus.md_op  = OP_MTLO;
    bus.rs_val = 32'h9ABCDEF0;
    push_exp(32'h12345678, 32'h80000000, 0, "mthi");
    strobe = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.md_op = OP_NONE;
    push_exp(32'h12345678, 32'h9ABCDEF0, 0, "mtlo");
    @(posedge clk);
    #1;
    strobe = 1'b0;

    // MULT during a DIV is dropped; only the DIV commits.
    push_exp(32'd2, 32'd14, 10, "div_busy_ignore");
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    issue(OP_MULT, 32'd3, 32'd3, 1'b0);
    wait_idle("div_busy_ignore");

    issue(OP_MULTU, 32'd5, 32'd5, 1'b1);
    probe(32'd2, 32'd14, "req_mult");
    issue(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b1);
    probe(32'd2, 32'd14, "req_mthi");
    issue(4'hF, 32'd1, 32'd1, 1'b0);
    probe(32'd2, 32'd14, "undefined_op");
    issue(OP_NONE, 32'd1, 32'd1, 1'b0);
    probe(32'd2, 32'd14, "none_op");

    // Second launch in the first cycle busy is low.
    push_exp(32'd1, 32'd0, 5, "b2b_multu");
    issue(OP_MULTU, 32'h00010000, 32'h00010000, 1'b0);
    wait_idle("b2b_multu");
    push_exp(32'hFFFFFFFF, 32'hFFFFFFF9, 5, "b2b_mult");
    issue(OP_MULT, 32'd7, 32'hFFFFFFFF, 1'b0);
    wait_idle("b2b_mult");

    issue(OP_MTHI, 32'h0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    push_exp(32'd1, 32'd0, 5, "maddu");
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
    wait_idle("maddu");
    push_exp(32'd0, 32'hFFFFFFFF, 5, "msub");
    issue(OP_MSUB, 32'd1, 32'd1, 1'b0);
    wait_idle("msub");
    push_exp(32'd0, 32'hFFFFFFFD, 5, "madd_neg");
    issue(OP_MADD, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle("madd_neg");
`else
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
    probe(32'd0, 32'hFFFFFFFF, "maddu_disabled");
`endif

    // Reset in the third busy cycle of a DIV aborts it for good.
    push_exp(32'd0, 32'd0, 3, "div_reset_abort");
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    probe(32'd0, 32'd0, "no_late_commit");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
